// File: rtl/lockstep_checker.sv
// rtl/lockstep_checker.sv - masked, skew-aligned lockstep compare of golden (a) vs candidate (b)
// Optional macro LOCKSTEP_CAPTURE_EN adds first_a/first_b capture of the first failing compare.
module lockstep_checker #(
    parameter int WIDTH  = 237,
    parameter int SKEW   = 0,
    parameter int IGNORE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    input  logic             cmp_en,
    input  logic             halt_on_err,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             mismatch,
    output logic [WIDTH-1:0] diff,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      first_cycle,
    output logic             halted,
    output logic             armed
`ifdef LOCKSTEP_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b
`endif
);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Warm-up must also cover the skew pipe filling, so it lasts max(IGNORE, SKEW) cycles.
    localparam int WARM      = (IGNORE > SKEW) ? IGNORE : SKEW;
    localparam int WARM_LAST = (WARM > 0) ? WARM - 1 : 0;
    localparam int WARM_W    = (WARM_LAST < 2) ? 1 : $clog2(WARM_LAST + 1);

    logic [WIDTH-1:0]  a_d;
    logic [WIDTH-1:0]  raw;
    logic              fail;
    logic              clr_eff;
    logic [1:0]        state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [31:0]       cycle_cnt_q;
    logic              mismatch_q, mismatch_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       first_q, first_d;
`ifdef LOCKSTEP_CAPTURE_EN
    logic [WIDTH-1:0]  first_a_q, first_a_d;
    logic [WIDTH-1:0]  first_b_q, first_b_d;
`endif

    generate
        if (SKEW == 0) begin : g_noskew
            assign a_d = a;
        end else begin : g_skew
            logic [WIDTH-1:0] pipe_q [SKEW];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SKEW; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= a;
                    for (int i = 1; i < SKEW; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign a_d = pipe_q[SKEW-1];
        end
    endgenerate

    assign raw     = (a_d ^ b) & mask;
    assign clr_eff = clr && (state_q != ST_WARMUP);
    // clr takes priority: a failing compare in the same cycle is discarded entirely.
    assign fail    = (state_q == ST_ARMED) && cmp_en && (|raw) && !clr;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        mismatch_d = fail;
        diff_d     = diff_q;
        sticky_d   = sticky_q;
        count_d    = count_q;
        first_d    = first_q;
`ifdef LOCKSTEP_CAPTURE_EN
        first_a_d  = first_a_q;
        first_b_d  = first_b_q;
`endif
        case (state_q)
            ST_WARMUP: begin
                warm_cnt_d = warm_cnt_q + WARM_W'(1);
                if (warm_cnt_q == WARM_W'(WARM_LAST)) state_d = ST_ARMED;
            end
            ST_ARMED:  if (fail && halt_on_err) state_d = ST_HALTED;
            ST_HALTED: if (clr) state_d = ST_ARMED;
            default:   state_d = ST_WARMUP;
        endcase
        if (clr_eff) begin
            diff_d   = '0;
            sticky_d = 1'b0;
            count_d  = '0;
            first_d  = '0;
`ifdef LOCKSTEP_CAPTURE_EN
            first_a_d = '0;
            first_b_d = '0;
`endif
        end else if (fail) begin
            diff_d   = raw;
            sticky_d = 1'b1;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (!sticky_q) begin
                first_d = cycle_cnt_q;
`ifdef LOCKSTEP_CAPTURE_EN
                first_a_d = a_d;
                first_b_d = b;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            diff_q      <= '0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
            first_q     <= '0;
`ifdef LOCKSTEP_CAPTURE_EN
            first_a_q   <= '0;
            first_b_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            mismatch_q  <= mismatch_d;
            diff_q      <= diff_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
            first_q     <= first_d;
`ifdef LOCKSTEP_CAPTURE_EN
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
`endif
        end
    end

    assign dout        = a;
    assign mismatch    = mismatch_q;
    assign diff        = diff_q;
    assign err_sticky  = sticky_q;
    assign err_count   = count_q;
    assign first_cycle = first_q;
    assign halted      = (state_q == ST_HALTED);
    assign armed       = (state_q == ST_ARMED);
`ifdef LOCKSTEP_CAPTURE_EN
    assign first_a     = first_a_q;
    assign first_b     = first_b_q;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// tb/tb_lockstep_checker.sv - vector table + scoreboard bench for lockstep_checker
// Four instances share stimulus: d0 (SKEW0), d1 (SKEW3), d2 (SKEW2), d3 (CNT_W=4).
module tb_lockstep_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b, mask;
    logic       cmp_en, halt_on_err, clr;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  d0_dout, d0_diff, d1_dout, d1_diff, d2_dout, d2_diff, d3_dout, d3_diff;
    logic        d0_mm, d0_st, d0_hl, d0_ar, d1_mm, d1_st, d1_hl, d1_ar;
    logic        d2_mm, d2_st, d2_hl, d2_ar, d3_mm, d3_st, d3_hl, d3_ar;
    logic [15:0] d0_cnt, d1_cnt, d2_cnt;
    logic [3:0]  d3_cnt;
    logic [31:0] d0_fc, d1_fc, d2_fc, d3_fc;
`ifdef LOCKSTEP_CAPTURE_EN
    logic [7:0]  d0_fa, d0_fb, d1_fa, d1_fb, d2_fa, d2_fb, d3_fa, d3_fb;
`endif

    lockstep_checker #(.WIDTH(8), .SKEW(0), .IGNORE(2), .CNT_W(16)) u_d0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .mask(mask), .cmp_en(cmp_en),
        .halt_on_err(halt_on_err), .clr(clr), .dout(d0_dout), .mismatch(d0_mm),
        .diff(d0_diff), .err_sticky(d0_st), .err_count(d0_cnt), .first_cycle(d0_fc),
        .halted(d0_hl), .armed(d0_ar)
`ifdef LOCKSTEP_CAPTURE_EN
        , .first_a(d0_fa), .first_b(d0_fb)
`endif
    );

    lockstep_checker #(.WIDTH(8), .SKEW(3), .IGNORE(2), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .mask(mask), .cmp_en(cmp_en),
        .halt_on_err(halt_on_err), .clr(clr), .dout(d1_dout), .mismatch(d1_mm),
        .diff(d1_diff), .err_sticky(d1_st), .err_count(d1_cnt), .first_cycle(d1_fc),
        .halted(d1_hl), .armed(d1_ar)
`ifdef LOCKSTEP_CAPTURE_EN
        , .first_a(d1_fa), .first_b(d1_fb)
`endif
    );

    lockstep_checker #(.WIDTH(8), .SKEW(2), .IGNORE(2), .CNT_W(16)) u_d2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .mask(mask), .cmp_en(cmp_en),
        .halt_on_err(halt_on_err), .clr(clr), .dout(d2_dout), .mismatch(d2_mm),
        .diff(d2_diff), .err_sticky(d2_st), .err_count(d2_cnt), .first_cycle(d2_fc),
        .halted(d2_hl), .armed(d2_ar)
`ifdef LOCKSTEP_CAPTURE_EN
        , .first_a(d2_fa), .first_b(d2_fb)
`endif
    );

    lockstep_checker #(.WIDTH(8), .SKEW(0), .IGNORE(2), .CNT_W(4)) u_d3 (
        .clk(clk), .reset(reset), .a(a), .b(b), .mask(mask), .cmp_en(cmp_en),
        .halt_on_err(halt_on_err), .clr(clr), .dout(d3_dout), .mismatch(d3_mm),
        .diff(d3_diff), .err_sticky(d3_st), .err_count(d3_cnt), .first_cycle(d3_fc),
        .halted(d3_hl), .armed(d3_ar)
`ifdef LOCKSTEP_CAPTURE_EN
        , .first_a(d3_fa), .first_b(d3_fb)
`endif
    );

    typedef struct {
        logic        rst;
        logic [7:0]  a, b, mask;
        logic        en, halt, clr;
        logic        mm;
        logic [7:0]  diff;
        logic        st;
        logic [15:0] cnt;
        logic [31:0] fc;
        logic        hl, ar;
        logic [7:0]  fa, fb;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t v(input logic rst, input logic [7:0] ia, ib, im,
                               input logic en, hl_in, cl, mm, input logic [7:0] df,
                               input logic st, input logic [15:0] cnt, input logic [31:0] fc,
                               input logic hl, ar, input logic [7:0] fa, fb);
        vec_t r;
        r.rst = rst; r.a = ia; r.b = ib; r.mask = im; r.en = en; r.halt = hl_in; r.clr = cl;
        r.mm = mm; r.diff = df; r.st = st; r.cnt = cnt; r.fc = fc; r.hl = hl; r.ar = ar;
        r.fa = fa; r.fb = fb;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; a = 8'h00; b = 8'h00; mask = 8'hFF;
        cmp_en = 1'b1; halt_on_err = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] hist [40];
    int         p1, p2, p3;
    vec_t       e;

    initial begin
        reset = 1'b1; a = 8'h00; b = 8'h00; mask = 8'hFF;
        cmp_en = 1'b1; halt_on_err = 1'b0; clr = 1'b0;

        //          rst a     b     mask  en hlt clr mm diff  st cnt fc  hl ar fa     fb
        tbl.push_back(v(1, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h5B, 8'hFF, 1, 0, 0, 1, 8'h01, 1, 1, 5,  0, 1, 8'h5A, 8'h5B));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 0, 0, 8'h01, 1, 1, 5,  0, 1, 8'h5A, 8'h5B));
        tbl.push_back(v(0, 8'h5A, 8'h5B, 8'hFE, 1, 0, 0, 0, 8'h01, 1, 1, 5,  0, 1, 8'h5A, 8'h5B));
        tbl.push_back(v(0, 8'h5A, 8'h5B, 8'hFF, 0, 0, 0, 0, 8'h01, 1, 1, 5,  0, 1, 8'h5A, 8'h5B));
        tbl.push_back(v(0, 8'h5A, 8'hDB, 8'hFF, 1, 0, 0, 1, 8'h81, 1, 2, 5,  0, 1, 8'h5A, 8'h5B));
        tbl.push_back(v(0, 8'h5A, 8'h5A, 8'hFF, 1, 0, 1, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h4A, 8'hFF, 1, 0, 1, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h5A, 8'h4A, 8'hFF, 1, 1, 0, 1, 8'h10, 1, 1, 12, 1, 0, 8'h5A, 8'h4A));
        tbl.push_back(v(0, 8'h5A, 8'h4A, 8'hFF, 1, 1, 0, 0, 8'h10, 1, 1, 12, 1, 0, 8'h5A, 8'h4A));
        tbl.push_back(v(0, 8'h5A, 8'h5B, 8'hFF, 1, 0, 0, 0, 8'h10, 1, 1, 12, 1, 0, 8'h5A, 8'h4A));
        tbl.push_back(v(0, 8'h5A, 8'h4A, 8'hFF, 1, 1, 1, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h3C, 8'h3D, 8'hFF, 1, 0, 0, 1, 8'h01, 1, 1, 16, 0, 1, 8'h3C, 8'h3D));
        tbl.push_back(v(1, 8'h3C, 8'h3D, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h3C, 8'h3D, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h3C, 8'h3D, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 0, 0,  0, 1, 8'h00, 8'h00));
        tbl.push_back(v(0, 8'h3C, 8'h3D, 8'hFF, 1, 0, 0, 1, 8'h01, 1, 1, 2,  0, 1, 8'h3C, 8'h3D));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; a = tbl[i].a; b = tbl[i].b; mask = tbl[i].mask;
            cmp_en = tbl[i].en; halt_on_err = tbl[i].halt; clr = tbl[i].clr;
            exp_q.push_back(tbl[i]);
            #1;
            chk($sformatf("r%0d_dout", i), d0_dout, tbl[i].a);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("r%0d_mismatch", i), d0_mm, e.mm);
            chk($sformatf("r%0d_diff", i), d0_diff, e.diff);
            chk($sformatf("r%0d_sticky", i), d0_st, e.st);
            chk($sformatf("r%0d_count", i), d0_cnt, e.cnt);
            chk($sformatf("r%0d_first_cycle", i), d0_fc, e.fc);
            chk($sformatf("r%0d_halted", i), d0_hl, e.hl);
            chk($sformatf("r%0d_armed", i), d0_ar, e.ar);
`ifdef LOCKSTEP_CAPTURE_EN
            chk($sformatf("r%0d_first_a", i), d0_fa, e.fa);
            chk($sformatf("r%0d_first_b", i), d0_fb, e.fb);
`endif
        end

        // Skew alignment: b is a delayed by three cycles.
        do_reset();
        p1 = 0; p2 = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            reset = 1'b0;
            hist[t] = 8'(t * 7 + 3);
            a = hist[t];
            b = (t >= 3) ? hist[t-3] : 8'h00;
            #1;
            if (t == 10) chk("skew_dout_passthrough", d1_dout, hist[t]);
            @(posedge clk);
            #1;
            if (d1_mm) p1++;
            if (d2_mm) p2++;
        end
        chk("skew3_pulses", p1, 0);
        chk("skew3_count", d1_cnt, 0);
        chk("skew3_sticky", d1_st, 0);
        chk("skew3_armed", d1_ar, 1);
        chk("skew2_pulses", p2, 38);
        chk("skew2_count", d2_cnt, 38);
        chk("skew2_first_cycle", d2_fc, 2);

        // Saturation with CNT_W=4, then clr on a failing cycle.
        do_reset();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            reset = 1'b0; a = 8'h11; b = 8'h11;
            @(posedge clk);
            #1;
        end
        p3 = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            a = 8'(t); b = ~8'(t);
            @(posedge clk);
            #1;
            if (d3_mm) p3++;
            if (t == 14) chk("sat_count_at_15", d3_cnt, 15);
        end
        chk("sat_pulses", p3, 20);
        chk("sat_count", d3_cnt, 4'hF);
        chk("sat_first_cycle", d3_fc, 2);
        chk("wide_count", d0_cnt, 20);
        @(negedge clk);
        a = 8'h00; b = 8'hFF; clr = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_clr_count", d3_cnt, 0);
        chk("sat_clr_pulse", d3_mm, 0);
        chk("sat_clr_sticky", d3_st, 0);
        chk("sat_clr_diff", d3_diff, 0);
        @(negedge clk);
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
